// File: rtl/uart_tx_sched.sv
// uart_tx_sched: buffers UART-mapped store bytes in a circular FIFO and hands
// them one at a time to the UART transmitter via byte_ready / t_byte.
// The pipeline is stalled while the FIFO is full, so no store byte is lost.
module uart_tx_sched #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    stall,
   input  logic                    tx_busy,
   output logic [DATA_W-1:0]       data_in,
   output logic                    byte_ready,
   output logic                    t_byte,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      START     = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic [PW-1:0]       rd_ptr_r;
   logic [PW-1:0]       wr_ptr_r;
   logic [PW:0]         count_r;
   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic [DATA_W-1:0]   data_in_r;
   logic                byte_ready_r;
   logic                t_byte_r;
   logic                push_s;
   logic                pop_s;
   logic                byte_ready_next_s;
   logic                t_byte_next_s;

   // full is registered occupancy, so stall never loops back through the FIFO
   assign empty      = (count_r == CNT_ZERO);
   assign full       = (count_r == CNT_FULL);
   assign stall      = wr_en & full;
   assign push_s     = wr_en & ~full;
   assign count      = count_r;
   assign data_in    = data_in_r;
   assign byte_ready = byte_ready_r;
   assign t_byte     = t_byte_r;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; a pop happens only on entry to LOAD
   always_comb begin
      state_next_s = state_r;
      pop_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty) begin
               pop_s        = 1'b1;
               state_next_s = LOAD;
            end else begin
               state_next_s = IDLE;
            end
         end
         LOAD:  state_next_s = START;
         START: state_next_s = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_next_s = WAIT_DONE;
            end else begin
               state_next_s = WAIT_BUSY;
            end
         end
         WAIT_DONE: begin
            if (tx_busy) begin
               state_next_s = WAIT_DONE;
            end else if (!empty) begin
               pop_s        = 1'b1;
               state_next_s = LOAD;
            end else begin
               state_next_s = IDLE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // FSM outputs: decoded from the next state so the registered pulses line up with LOAD/START
   always_comb begin
      byte_ready_next_s = 1'b0;
      t_byte_next_s     = 1'b0;
      case (state_next_s)
         LOAD:    byte_ready_next_s = 1'b1;
         START:   t_byte_next_s     = 1'b1;
         default: begin
            byte_ready_next_s = 1'b0;
            t_byte_next_s     = 1'b0;
         end
      endcase
   end

   // Registered handshake pulses toward the transmitter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_ready_r <= 1'b0;
         t_byte_r     <= 1'b0;
      end else begin
         byte_ready_r <= byte_ready_next_s;
         t_byte_r     <= t_byte_next_s;
      end
   end

   // FIFO pointers, occupancy and the presented byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_r  <= {PW{1'b0}};
         wr_ptr_r  <= {PW{1'b0}};
         count_r   <= CNT_ZERO;
         data_in_r <= {DATA_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            data_in_r <= mem_r[rd_ptr_r];
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: the bench plays both the store
// pipeline and the transmitter, and compares every cycle against a queue model.
module tb_uart_tx_sched;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 8;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic                   wr_en = 1'b0;
   logic [DATA_W-1:0]      wr_data = 8'h00;
   logic                   tx_busy = 1'b0;
   logic                   stall;
   logic [DATA_W-1:0]      data_in;
   logic                   byte_ready;
   logic                   t_byte;
   logic                   empty;
   logic                   full;
   logic [$clog2(DEPTH):0] count;

   uart_tx_sched #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .stall(stall),
      .tx_busy(tx_busy), .data_in(data_in), .byte_ready(byte_ready), .t_byte(t_byte),
      .empty(empty), .full(full), .count(count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model: FIFO contents, last handed-over byte, frame progress
   logic [7:0] q[$];
   logic [7:0] dir_q[$];
   logic [7:0] m_data;
   bit         m_active;
   bit         m_busy_seen;
   int         m_since;
   bit         m_stalled;
   int         tx_dly, tx_len;
   int         wr_pct, len_lo, len_hi;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_data      = 8'h00;
      m_active    = 1'b0;
      m_busy_seen = 1'b0;
      m_since     = 0;
      m_stalled   = 1'b0;
   endfunction

   // what the next rising edge does, from the inputs now being driven
   function automatic void model_edge();
      int n;
      n = q.size();
      if (m_active) begin
         if (m_busy_seen && !tx_busy) m_active = 1'b0;
         else if (m_since >= 2 && tx_busy) m_busy_seen = 1'b1;
         if (m_since < 3) m_since++;
      end
      if (!m_active && n > 0) begin
         m_data      = q.pop_front();
         m_active    = 1'b1;
         m_busy_seen = 1'b0;
         m_since     = 0;
      end
      if (wr_en && n < DEPTH) q.push_back(wr_data);
      m_stalled = wr_en && (n == DEPTH);
   endfunction

   task automatic check_outputs();
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("data_in", 32'(data_in), 32'(m_data));
      chk("byte_ready", 32'(byte_ready), 32'(m_active && m_since == 0));
      chk("t_byte", 32'(t_byte), 32'(m_active && m_since == 1));
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      if (t_byte) begin
         tx_dly = $urandom_range(0, 2);
         tx_len = $urandom_range(len_lo, len_hi);
      end
      if (tx_dly > 0) begin
         tx_dly--;
         tx_busy = 1'b0;
      end else if (tx_len > 0) begin
         tx_busy = 1'b1;
         tx_len--;
      end else begin
         tx_busy = 1'b0;
      end
      if (m_stalled) begin
         wr_en = 1'b1;
      end else if (dir_q.size() > 0) begin
         wr_en   = 1'b1;
         wr_data = dir_q.pop_front();
      end else if ($urandom_range(0, 99) < wr_pct) begin
         wr_en   = 1'b1;
         wr_data = 8'($urandom);
      end else begin
         wr_en = 1'b0;
      end
      #1;
      chk("stall", 32'(stall), 32'(wr_en && q.size() == DEPTH));
      model_edge();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b0;
      wr_en   = 1'b0;
      tx_busy = 1'b0;
      tx_dly  = 0;
      tx_len  = 0;
      dir_q.delete();
      model_reset();
      #1;
      check_outputs();
      chk("stall_rst", 32'(stall), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check_outputs();
      end
      reset = 1'b1;
      model_edge();
   endtask

   initial begin
      tx_dly = 0; tx_len = 0; wr_pct = 0; len_lo = 10; len_hi = 10;
      do_reset();

      // single byte, transmitter busy for 10 cycles
      dir_q.push_back(8'h41);
      repeat (30) cycle();

      // ordering and pointer wrap with re-presented stalled stores
      len_lo = 3; len_hi = 8;
      for (int i = 0; i < 12; i++) dir_q.push_back(8'(8'h10 + i));
      repeat (150) cycle();

      // fill to full behind a long frame, then drain
      len_lo = 40; len_hi = 40; wr_pct = 100;
      repeat (70) cycle();
      len_lo = 2; len_hi = 6; wr_pct = 0;
      repeat (100) cycle();

      // randomized traffic
      len_lo = 2; len_hi = 8; wr_pct = 40;
      repeat (2000) cycle();

      // reset in the middle of a frame with bytes queued
      len_lo = 30; len_hi = 30; wr_pct = 0;
      repeat (5) cycle();
      for (int i = 0; i < 4; i++) dir_q.push_back(8'(8'hA0 + i));
      repeat (6) cycle();
      do_reset();

      // idle hold: no handshake without a push
      len_lo = 2; len_hi = 8; wr_pct = 0;
      repeat (25) cycle();

      // more randomized traffic with heavier writes
      wr_pct = 70; len_lo = 2; len_hi = 12;
      repeat (1500) cycle();
      wr_pct = 0;
      repeat (200) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
